// File: rtl/xbar_arb_pkg.sv
// Shared types and sizing helpers for the crossbar output-port arbiter.
package xbar_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first set request searching
// upward from i_last+1, wrapping modulo N.
module rr_priority_picker
  import xbar_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  localparam int PW = IW + 1;

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic [PW-1:0]  w_pos;

  // Lower half holds only requests above i_last, upper half the full vector,
  // so the lowest set bit of the doubled vector is the wrapped winner.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (IW'(i) > i_last);
    end
    w_dbl = {i_req, i_req & w_mask};
    w_pos = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      w_pos = w_dbl[i] ? PW'(i) : w_pos;
    end
  end

  // Fold the doubled position back into a requester index and decode it.
  always_comb begin
    o_any = |i_req;
    if (w_pos >= PW'(N)) begin
      o_idx = IW'(w_pos - PW'(N));
    end else begin
      o_idx = IW'(w_pos);
    end
    o_onehot = '0;
    if (o_any) begin
      o_onehot[o_idx] = 1'b1;
    end else begin
      o_onehot = '0;
    end
  end

endmodule

// File: rtl/xbar_output_arbiter.sv
// Round-robin burst scheduler sharing one crossbar output port between
// NUM_REQ show-ahead FIFOs, with a registered valid/ready output stage.
module xbar_output_arbiter
  import xbar_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int IW         = idx_width(NUM_REQ),
  parameter int BW         = idx_width(BURST_LEN)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_empty_rx,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_do_rx,
  output logic [NUM_REQ-1:0]            o_pop_rx,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [DATA_WIDTH-1:0]         o_out_data,
  output logic [IW-1:0]                 o_out_src,
  output logic                          o_grant_active
);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [IW-1:0]         r_sel;
  logic [NUM_REQ-1:0]    r_sel_oh;
  logic [IW-1:0]         r_last_grant;
  logic [BW-1:0]         r_burst_cnt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [IW-1:0]         r_out_src;

  logic [NUM_REQ-1:0]    w_pick_onehot;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_pick_any;
  logic                  w_sel_empty;
  logic                  w_can_pop;
  logic                  w_burst_last;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .i_req    (~i_empty_rx),
    .i_last   (r_last_grant),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Pop qualification; reset suppresses any pop in the reset cycle.
  always_comb begin
    w_sel_empty  = i_empty_rx[r_sel];
    w_burst_last = (r_burst_cnt == BW'(BURST_LEN - 1));
    w_can_pop    = ~i_rst & (r_state == ARB_XFER) & ~w_sel_empty
                 & (~r_out_valid | i_out_ready);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          w_next_state = ARB_XFER;
        end else begin
          w_next_state = ARB_IDLE;
        end
      end
      ARB_XFER: begin
        if (w_sel_empty | (w_can_pop & w_burst_last)) begin
          w_next_state = ARB_IDLE;
        end else begin
          w_next_state = ARB_XFER;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    o_pop_rx       = w_can_pop ? r_sel_oh : '0;
    o_grant_active = (r_state == ARB_XFER);
  end

  // Grant bookkeeping and the output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel        <= '0;
      r_sel_oh     <= '0;
      r_last_grant <= IW'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= '0;
    end else begin
      if ((r_state == ARB_IDLE) && w_pick_any) begin
        r_sel        <= w_pick_idx;
        r_sel_oh     <= w_pick_onehot;
        r_last_grant <= w_pick_idx;
        r_burst_cnt  <= '0;
      end else if (w_can_pop) begin
        r_burst_cnt  <= r_burst_cnt + BW'(1);
      end
      // A pop refills the register even while the old word is being taken.
      if (w_can_pop) begin
        r_out_data  <= i_do_rx[r_sel*DATA_WIDTH +: DATA_WIDTH];
        r_out_src   <= r_sel;
        r_out_valid <= 1'b1;
      end else if (r_out_valid & i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_src   = r_out_src;

endmodule

// File: tb/tb_xbar_output_arbiter.sv
// Scoreboard bench for xbar_output_arbiter: FIFO models feed the DUT, the
// stimulus pushes hand-computed words and arrival cycles, a monitor checks.
module tb_xbar_output_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct {
    logic [IW-1:0] src;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  empty_rx;
  logic [NR*DW-1:0] do_rx;
  logic [NR-1:0]  pop_rx;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [IW-1:0]  out_src;
  logic           grant_active;

  logic [NR-1:0]  rr_empty;
  logic [NR*DW-1:0] rr_do;
  logic [NR-1:0]  rr_pop;
  logic           rr_valid;
  logic           rr_ready;
  logic [DW-1:0]  rr_data;
  logic [IW-1:0]  rr_src;
  logic           rr_grant;

  exp_t          sb[$];
  exp_t          rr_sb[$];
  logic [DW-1:0] fq[NR][$];
  logic [NR-1:0] pop_s;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;

  always #5 clk = ~clk;

  xbar_output_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_empty_rx(empty_rx), .i_do_rx(do_rx),
    .o_pop_rx(pop_rx), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_src(out_src), .o_grant_active(grant_active)
  );

  xbar_output_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(1)) u_rr (
    .i_clk(clk), .i_rst(rst), .i_empty_rx(rr_empty), .i_do_rx(rr_do),
    .o_pop_rx(rr_pop), .o_out_valid(rr_valid), .i_out_ready(rr_ready),
    .o_out_data(rr_data), .o_out_src(rr_src), .o_grant_active(rr_grant)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      empty_rx[i] = (fq[i].size() == 0);
      do_rx[i*DW +: DW] = (fq[i].size() == 0) ? 32'h0 : fq[i][0];
    end
  endtask

  // Advance one cycle; retire words the DUT popped in the cycle just ended.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (pop_s[i] && (fq[i].size() > 0)) void'(fq[i].pop_front());
    end
    refresh();
  endtask

  task automatic fill(input int f, input logic [DW-1:0] base, input int n);
    for (int k = 0; k < n; k++) fq[f].push_back(base + DW'(k));
    refresh();
  endtask

  task automatic expw(input int src, input logic [DW-1:0] d, input int c);
    exp_t e;
    e.src = IW'(src); e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d words outstanding, want 0", sb.size());
      sb.delete();
    end
    repeat (3) step();
  endtask

  // Monitor: legality of pops every cycle, scoreboard on each handshake.
  always @(negedge clk) begin
    exp_t e;
    pop_s = pop_rx;
    chk("pop_legal", {63'b0, ((pop_rx & empty_rx) == '0) && $onehot0(pop_rx)}, 64'd1);
    chk("rr_pop_legal", {63'b0, ((rr_pop & rr_empty) == '0) && $onehot0(rr_pop)}, 64'd1);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_word: got src %0d data %0h, want no word", out_src, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_src", 64'(out_src), 64'(e.src));
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (rr_valid && rr_ready && (rr_sb.size() > 0)) begin
      e = rr_sb.pop_front();
      chk("rr_src", 64'(rr_src), 64'(e.src));
      chk("rr_data", 64'(rr_data), 64'(e.data));
      chk("rr_cycle", 64'(cyc), 64'(e.cyc));
    end
  end

  initial begin
    int t;
    int o2[6];
    int n;
    rst = 1'b1; out_ready = 1'b1; rr_ready = 1'b1; pop_s = '0;
    refresh();
    rr_empty = '1;
    rr_do = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    step(); step();
    rst = 1'b0;

    // Idle after reset: nothing may move.
    repeat (10) begin
      step(); #1;
      chk("rst_pop", 64'(pop_rx), 64'h0);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_grant", 64'(grant_active), 64'h0);
      chk("rr_rst_grant", 64'(rr_grant), 64'h0);
    end
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_src", 64'(out_src), 64'h0);

    // BURST_LEN=1 instance, all FIFOs always non-empty.
    step(); t = cyc;
    rr_empty = '0;
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e.src = IW'(k % 4); e.data = 32'hB0 + DW'(k % 4); e.cyc = t + 2 + 2*k;
      rr_sb.push_back(e);
    end
    n = 0;
    while (rr_sb.size() > 0 && n < 60) begin step(); n++; end
    if (rr_sb.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL rr_timeout: %0d words outstanding, want 0", rr_sb.size());
      rr_sb.delete();
    end
    rr_empty = '1;
    repeat (4) step();

    // FIFO 2 with six words: burst of four, one idle cycle, then two more.
    step(); t = cyc;
    fill(2, 32'hA0, 6);
    o2 = '{2, 3, 4, 5, 7, 8};
    for (int k = 0; k < 6; k++) expw(2, 32'hA0 + DW'(k), t + o2[k]);
    drain();

    // Backpressure for five cycles mid-burst on FIFO 0.
    step(); t = cyc;
    fill(0, 32'hC0, 4);
    expw(0, 32'hC0, t + 2); expw(0, 32'hC1, t + 8);
    expw(0, 32'hC2, t + 9); expw(0, 32'hC3, t + 10);
    step(); step(); step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_pop", 64'(pop_rx), 64'h0);
      chk("stall_data", 64'(out_data), 64'hC1);
      chk("stall_valid", 64'(out_valid), 64'h1);
      chk("stall_grant", 64'(grant_active), 64'h1);
      step();
    end
    out_ready = 1'b1;
    drain();

    // FIFO 1 runs dry after two words; FIFO 3 is served next.
    step(); t = cyc;
    fill(1, 32'hD0, 2);
    fill(3, 32'hE0, 2);
    expw(1, 32'hD0, t + 2); expw(1, 32'hD1, t + 3);
    expw(3, 32'hE0, t + 6); expw(3, 32'hE1, t + 7);
    drain();

    // Reset pulse mid-burst on FIFO 1; FIFO 0 wins the next arbitration.
    step(); t = cyc;
    fill(1, 32'hF0, 6);
    expw(1, 32'hF0, t + 2); expw(1, 32'hF1, t + 3);
    step(); step(); step();
    rst = 1'b1;
    fill(0, 32'h60, 1);
    #1;
    chk("rst_cycle_pop", 64'(pop_rx), 64'h0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'h0);
    chk("post_rst_data", 64'(out_data), 64'h0);
    chk("post_rst_src", 64'(out_src), 64'h0);
    chk("post_rst_grant", 64'(grant_active), 64'h0);
    chk("post_rst_pop", 64'(pop_rx), 64'h0);
    expw(0, 32'h60, t + 6);
    for (int k = 0; k < 4; k++) expw(1, 32'hF2 + DW'(k), t + 9 + k);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
